// File: rtl/output_port_arbiter.sv
// Per-output-port wormhole arbiter: round-robin among head flits, then the
// port stays locked to the winning input until its tail flit is transferred.
module output_port_arbiter #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned SEL_W   = $clog2(NUM_REQ),
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_head,
    input  logic [NUM_REQ-1:0] i_tail,
    input  logic               i_on,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_valid,
    output logic [SEL_W-1:0]   o_sel,
    output logic               o_busy,
    output logic [SEL_W-1:0]   o_owner,
    output logic [CNT_W-1:0]   o_stall_cnt
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   w_next_ptr;
    logic [SEL_W-1:0]   r_owner;
    logic [SEL_W-1:0]   w_next_owner;
    logic [CNT_W-1:0]   r_stall;
    logic [CNT_W-1:0]   w_next_stall;
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_grant;
    logic [SEL_W-1:0]   w_win;
    logic [SEL_W-1:0]   w_sel;
    logic               w_found;
    logic               w_valid;
    int unsigned        w_idx;

    // Index after v, wrapping from the last input back to 0.
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
        return (v == LAST_IDX) ? '0 : v + SEL_W'(1);
    endfunction

    assign w_elig = i_req & i_head;

    // First eligible head flit scanning from the priority pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = (32'(r_ptr) + i) % NUM_REQ;
            if (!w_found && w_elig[SEL_W'(w_idx)]) begin
                w_found = 1'b1;
                w_win   = SEL_W'(w_idx);
            end
        end
    end

    // Grant generation, next-state and stall-counter logic.
    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        w_next_owner = r_owner;
        w_grant      = '0;
        w_sel        = '0;
        w_valid      = 1'b0;
        w_next_stall = '0;

        case (r_state)
            IDLE: begin
                if (i_on && w_found) begin
                    w_grant[w_win] = 1'b1;
                    w_sel          = w_win;
                    w_next_ptr     = wrap_inc(w_win);
                    if (!i_tail[w_win]) begin
                        w_next_state = LOCKED;
                        w_next_owner = w_win;
                    end
                end
            end
            LOCKED: begin
                if (i_on && i_req[r_owner]) begin
                    w_grant[r_owner] = 1'b1;
                    w_sel            = r_owner;
                    if (i_tail[r_owner]) begin
                        w_next_state = IDLE;
                        w_next_ptr   = wrap_inc(r_owner);
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // No transfer may leave the port while reset is held.
        if (!reset_n) begin
            w_grant = '0;
            w_sel   = '0;
        end

        w_valid = |w_grant;

        if ((r_state == LOCKED) && !w_valid) begin
            w_next_stall = (r_stall == CNT_MAX) ? r_stall : r_stall + CNT_W'(1);
        end
    end

    // State, pointer, owner and stall counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_stall <= '0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
            r_owner <= w_next_owner;
            r_stall <= w_next_stall;
        end
    end

    assign o_grant     = w_grant;
    assign o_valid     = w_valid;
    assign o_sel       = w_sel;
    assign o_busy      = (r_state == LOCKED);
    assign o_owner     = r_owner;
    assign o_stall_cnt = r_stall;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: directed vector table, hand
// sequences for saturation and mid-packet reset, then randomized traffic
// checked against a behavioural model of the arbitration rules.
module tb_output_port_arbiter;

    localparam int N = 5;

    logic       clk;
    logic       reset_n;
    logic [4:0] i_req;
    logic [4:0] i_head;
    logic [4:0] i_tail;
    logic       i_on;

    logic [4:0] o_grant,  o_grant2;
    logic       o_valid,  o_valid2;
    logic [2:0] o_sel,    o_sel2;
    logic       o_busy,   o_busy2;
    logic [2:0] o_owner,  o_owner2;
    logic [7:0] o_stall_cnt;
    logic [1:0] o_stall_cnt2;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    bit m_locked;
    int m_owner;
    int m_ptr;
    int m_stall;
    int m_stall2;

    typedef struct {
        logic [4:0] req;
        logic [4:0] head;
        logic [4:0] tail;
        logic       on;
        logic [4:0] g;
        logic       busy;
        logic [7:0] stall;
    } vec_t;

    vec_t tbl [0:26];

    output_port_arbiter #(.NUM_REQ(5), .SEL_W(3), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .i_req(i_req), .i_head(i_head),
        .i_tail(i_tail), .i_on(i_on), .o_grant(o_grant), .o_valid(o_valid),
        .o_sel(o_sel), .o_busy(o_busy), .o_owner(o_owner), .o_stall_cnt(o_stall_cnt)
    );

    output_port_arbiter #(.NUM_REQ(5), .SEL_W(3), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .i_req(i_req), .i_head(i_head),
        .i_tail(i_tail), .i_on(i_on), .o_grant(o_grant2), .o_valid(o_valid2),
        .o_sel(o_sel2), .o_busy(o_busy2), .o_owner(o_owner2), .o_stall_cnt(o_stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [4:0] g);
        int r = -1;
        for (int k = 0; k < N; k++) if (g[k] && r < 0) r = k;
        return r;
    endfunction

    function automatic logic [4:0] model_grant(input logic [4:0] req, input logic [4:0] head, input logic on);
        logic [4:0] g = '0;
        if (!on) return g;
        if (m_locked) begin
            if (req[3'(m_owner)]) g[3'(m_owner)] = 1'b1;
        end else begin
            for (int j = 0; j < N; j++) begin
                int k = (m_ptr + j) % N;
                if (g == 0 && req[3'(k)] && head[3'(k)]) g[3'(k)] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic model_update(input logic [4:0] g, input logic [4:0] tail);
        int  k   = idx_of(g);
        bit  was = m_locked;
        if (was && g == 0) begin
            m_stall  = (m_stall  < 255) ? m_stall  + 1 : 255;
            m_stall2 = (m_stall2 < 3)   ? m_stall2 + 1 : 3;
        end else begin
            m_stall  = 0;
            m_stall2 = 0;
        end
        if (k >= 0) begin
            if (!was) begin
                m_ptr = (k + 1) % N;
                if (!tail[3'(k)]) begin
                    m_locked = 1'b1;
                    m_owner  = k;
                end
            end else if (tail[3'(k)]) begin
                m_locked = 1'b0;
                m_ptr    = (k + 1) % N;
            end
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_stall = 0; m_stall2 = 0;
    endtask

    // Drive one cycle at the falling edge, check before the rising edge.
    task automatic apply(input logic [4:0] req, input logic [4:0] head, input logic [4:0] tail,
                         input logic on, input string tag);
        logic [4:0] g;
        int         k;
        i_req = req; i_head = head; i_tail = tail; i_on = on;
        #1;
        g = model_grant(req, head, on);
        k = idx_of(g);
        chk({tag, ".grant"},  32'(o_grant),      32'(g));
        chk({tag, ".grant2"}, 32'(o_grant2),     32'(g));
        chk({tag, ".valid"},  32'(o_valid),      32'(g != 0));
        chk({tag, ".sel"},    32'(o_sel),        (k < 0) ? 32'd0 : 32'(k));
        chk({tag, ".busy"},   32'(o_busy),       32'(m_locked));
        chk({tag, ".owner"},  32'(o_owner),      32'(m_owner));
        chk({tag, ".stall"},  32'(o_stall_cnt),  32'(m_stall));
        chk({tag, ".stall2"}, 32'(o_stall_cnt2), 32'(m_stall2));
        @(posedge clk);
        model_update(g, tail);
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] sat_exp [0:5];
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3; sat_exp[5] = 2'd3;

        //            req       head      tail      on    grant    busy  stall
        tbl[0]  = '{5'b11111, 5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b0, 8'd0};
        tbl[1]  = '{5'b00010, 5'b00010, 5'b00010, 1'b1, 5'b00010, 1'b0, 8'd0};
        tbl[2]  = '{5'b11010, 5'b11010, 5'b11010, 1'b1, 5'b01000, 1'b0, 8'd0};
        tbl[3]  = '{5'b11010, 5'b11010, 5'b11010, 1'b1, 5'b10000, 1'b0, 8'd0};
        tbl[4]  = '{5'b11010, 5'b11010, 5'b11010, 1'b1, 5'b00010, 1'b0, 8'd0};
        tbl[5]  = '{5'b11010, 5'b11010, 5'b11010, 1'b1, 5'b01000, 1'b0, 8'd0};
        tbl[6]  = '{5'b11010, 5'b11010, 5'b11010, 1'b1, 5'b10000, 1'b0, 8'd0};
        tbl[7]  = '{5'b11010, 5'b11010, 5'b11010, 1'b1, 5'b00010, 1'b0, 8'd0};
        tbl[8]  = '{5'b00101, 5'b00101, 5'b00001, 1'b1, 5'b00100, 1'b0, 8'd0};
        tbl[9]  = '{5'b00101, 5'b00001, 5'b00001, 1'b1, 5'b00100, 1'b1, 8'd0};
        tbl[10] = '{5'b00101, 5'b00001, 5'b00001, 1'b1, 5'b00100, 1'b1, 8'd0};
        tbl[11] = '{5'b00101, 5'b00001, 5'b00001, 1'b1, 5'b00100, 1'b1, 8'd0};
        tbl[12] = '{5'b00101, 5'b00001, 5'b00101, 1'b1, 5'b00100, 1'b1, 8'd0};
        tbl[13] = '{5'b00001, 5'b00001, 5'b00001, 1'b1, 5'b00001, 1'b0, 8'd0};
        tbl[14] = '{5'b01000, 5'b01000, 5'b00000, 1'b1, 5'b01000, 1'b0, 8'd0};
        tbl[15] = '{5'b01000, 5'b00000, 5'b00000, 1'b1, 5'b01000, 1'b1, 8'd0};
        tbl[16] = '{5'b01000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b1, 8'd0};
        tbl[17] = '{5'b01000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b1, 8'd1};
        tbl[18] = '{5'b01000, 5'b00000, 5'b01000, 1'b0, 5'b00000, 1'b1, 8'd2};
        tbl[19] = '{5'b01000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b1, 8'd3};
        tbl[20] = '{5'b01000, 5'b00000, 5'b00000, 1'b1, 5'b01000, 1'b1, 8'd4};
        tbl[21] = '{5'b01000, 5'b00000, 5'b01000, 1'b1, 5'b01000, 1'b1, 8'd0};
        tbl[22] = '{5'b10001, 5'b10001, 5'b00000, 1'b1, 5'b10000, 1'b0, 8'd0};
        tbl[23] = '{5'b10001, 5'b00001, 5'b10000, 1'b1, 5'b10000, 1'b1, 8'd0};
        tbl[24] = '{5'b10011, 5'b10011, 5'b10011, 1'b1, 5'b00001, 1'b0, 8'd0};
        tbl[25] = '{5'b00110, 5'b00000, 5'b00110, 1'b1, 5'b00000, 1'b0, 8'd0};
        tbl[26] = '{5'b00110, 5'b00110, 5'b00110, 1'b1, 5'b00010, 1'b0, 8'd0};

        // Reset held with every input requesting a head flit
        model_reset();
        reset_n = 1'b0;
        i_req = 5'b11111; i_head = 5'b11111; i_tail = 5'b11111; i_on = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.grant",  32'(o_grant),      32'd0);
        chk("rst.valid",  32'(o_valid),      32'd0);
        chk("rst.sel",    32'(o_sel),        32'd0);
        chk("rst.busy",   32'(o_busy),       32'd0);
        chk("rst.owner",  32'(o_owner),      32'd0);
        chk("rst.stall",  32'(o_stall_cnt),  32'd0);
        chk("rst.grant2", 32'(o_grant2),     32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed table: independent hand-derived expectations plus the model
        for (int i = 0; i < 27; i++) begin
            i_req = tbl[i].req; i_head = tbl[i].head; i_tail = tbl[i].tail; i_on = tbl[i].on;
            #1;
            chk($sformatf("tbl%0d.grant", i), 32'(o_grant),     32'(tbl[i].g));
            chk($sformatf("tbl%0d.busy", i),  32'(o_busy),      32'(tbl[i].busy));
            chk($sformatf("tbl%0d.stall", i), 32'(o_stall_cnt), 32'(tbl[i].stall));
            apply(tbl[i].req, tbl[i].head, tbl[i].tail, tbl[i].on, $sformatf("tbl%0d", i));
        end

        // Stall saturation: lock input 2 then hold i_on low for 6 cycles
        apply(5'b00100, 5'b00100, 5'b00000, 1'b1, "sat.head");
        for (int i = 0; i < 6; i++) begin
            apply(5'b00100, 5'b00000, 5'b00000, 1'b0, $sformatf("sat%0d", i));
            chk($sformatf("sat%0d.cnt2", i), 32'(o_stall_cnt2), 32'(sat_exp[i]));
            chk($sformatf("sat%0d.cnt8", i), 32'(o_stall_cnt),  32'(i + 1));
            chk($sformatf("sat%0d.own", i),  32'(o_owner),      32'd2);
        end
        apply(5'b00100, 5'b00000, 5'b00100, 1'b1, "sat.tail");

        // Reset asserted during a body flit of input 3
        apply(5'b01000, 5'b01000, 5'b00000, 1'b1, "mid.head");
        apply(5'b01000, 5'b00000, 5'b00000, 1'b1, "mid.body");
        i_req = 5'b01010; i_head = 5'b00010; i_tail = 5'b00010; i_on = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("mid.rst.busy",  32'(o_busy),      32'd0);
        chk("mid.rst.grant", 32'(o_grant),     32'd0);
        chk("mid.rst.valid", 32'(o_valid),     32'd0);
        chk("mid.rst.stall", 32'(o_stall_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("mid.rel.grant", 32'(o_grant), 32'(5'b00010));
        apply(5'b01010, 5'b00010, 5'b00010, 1'b1, "mid.rel");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            apply(5'($urandom), 5'($urandom), 5'($urandom), ($urandom_range(0, 3) != 0),
                  $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
